// File: rtl/mem_access_pkg.sv
// Shared opcodes, MEM-stage state codes and op-decoding helpers for the RV32I MEM stage.
// The optional misalignment trap (macro MISALIGN_TRAP_EN) uses isMisaligned from here.
package mem_access_pkg;

  localparam int EXEC_W     = 8;
  localparam int REG_ADDR_W = 5;

  localparam logic [EXEC_W-1:0] EXE_NOP_OP = 8'h00;
  localparam logic [EXEC_W-1:0] EXE_ADD_OP = 8'h01;
  localparam logic [EXEC_W-1:0] EXE_SUB_OP = 8'h02;
  localparam logic [EXEC_W-1:0] EXE_AND_OP = 8'h03;
  localparam logic [EXEC_W-1:0] EXE_OR_OP  = 8'h04;
  localparam logic [EXEC_W-1:0] EXE_LB_OP  = 8'h20;
  localparam logic [EXEC_W-1:0] EXE_LH_OP  = 8'h21;
  localparam logic [EXEC_W-1:0] EXE_LW_OP  = 8'h22;
  localparam logic [EXEC_W-1:0] EXE_LBU_OP = 8'h24;
  localparam logic [EXEC_W-1:0] EXE_LHU_OP = 8'h25;
  localparam logic [EXEC_W-1:0] EXE_SB_OP  = 8'h28;
  localparam logic [EXEC_W-1:0] EXE_SH_OP  = 8'h29;
  localparam logic [EXEC_W-1:0] EXE_SW_OP  = 8'h2A;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_XFER = 2'd1,
    MEM_WAIT = 2'd2,
    MEM_DONE = 2'd3
  } mem_state_e;

  function automatic logic isLoad(input logic [EXEC_W-1:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LH_OP) || (op == EXE_LW_OP) ||
           (op == EXE_LBU_OP) || (op == EXE_LHU_OP);
  endfunction

  function automatic logic isStore(input logic [EXEC_W-1:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  // Index of the final byte of the access: width minus one.
  function automatic logic [1:0] lastIdx(input logic [EXEC_W-1:0] op);
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2'd1;
      EXE_LW_OP, EXE_SW_OP:             return 2'd3;
      default:                          return 2'd0;
    endcase
  endfunction

  function automatic logic isMisaligned(input logic [EXEC_W-1:0] op, input logic [1:0] addrLo);
    case (lastIdx(op))
      2'd1:    return addrLo[0];
      2'd3:    return |addrLo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Load result extender: turns the byte-assembled memory word into the sign/zero-extended
// register value for LB/LBU/LH/LHU/LW.
module mem_access_load_ext
  import mem_access_pkg::*;
(
  input  logic [EXEC_W-1:0] i_op,
  input  logic [31:0]       i_word,
  output logic [31:0]       o_data
);

  always_comb begin
    o_data = i_word;
    case (i_op)
      EXE_LB_OP:  o_data = {{24{i_word[7]}}, i_word[7:0]};
      EXE_LBU_OP: o_data = {24'h000000, i_word[7:0]};
      EXE_LH_OP:  o_data = {{16{i_word[15]}}, i_word[15:0]};
      EXE_LHU_OP: o_data = {16'h0000, i_word[15:0]};
      default:    o_data = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: byte-serial load/store engine with a registered WB bundle and upstream stall.
// Optional macro MISALIGN_TRAP_EN skips misaligned half/word accesses and flags mem_misalign_o.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [EXEC_W-1:0]     ex_exec_i,
  input  logic [XLEN-1:0]       ex_alu_i,
  input  logic [XLEN-1:0]       ex_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rdest_i,
  input  logic                  ex_we_i,
  output logic                  mem_req_o,
  output logic                  mem_wr_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [7:0]            mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic [7:0]            mem_rdata_i,
  output logic                  stall_req_o,
  output logic [XLEN-1:0]       wb_data_o,
  output logic [REG_ADDR_W-1:0] wb_rdest_o,
  output logic                  wb_we_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                  mem_misalign_o
`endif
);

  mem_state_e            r_state;
  mem_state_e            w_nextState;
  logic [1:0]            r_idx;
  logic [EXEC_W-1:0]     r_op;
  logic [ADDR_W-1:0]     r_base;
  logic [XLEN-1:0]       r_rs2;
  logic [REG_ADDR_W-1:0] r_rdest;
  logic                  r_we;
  logic                  r_trap;
  logic [31:0]           r_word;
  logic                  r_capPending;
  logic [1:0]            r_capIdx;
  logic                  w_inMem;
  logic                  w_trapIn;
  logic                  w_stall;
  logic                  w_grant;
  logic [1:0]            w_lastIdx;
  logic [31:0]           w_ext;

  assign w_inMem   = isLoad(ex_exec_i) || isStore(ex_exec_i);
  assign w_lastIdx = lastIdx(r_op);

`ifdef MISALIGN_TRAP_EN
  assign w_trapIn = isMisaligned(ex_exec_i, ex_alu_i[1:0]);
`else
  assign w_trapIn = 1'b0;
`endif

  assign mem_req_o   = (r_state == MEM_XFER);
  assign mem_wr_o    = mem_req_o && isStore(r_op);
  assign mem_addr_o  = r_base + ADDR_W'(r_idx);
  assign mem_wdata_o = r_rs2[{r_idx, 3'b000} +: 8];
  assign w_grant     = mem_req_o && mem_gnt_i;
  assign stall_req_o = w_stall;

  always_comb begin
    w_nextState = r_state;
    w_stall     = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        if (w_inMem) begin
          w_stall     = 1'b1;
          w_nextState = w_trapIn ? MEM_DONE : MEM_XFER;
        end
      end
      MEM_XFER: begin
        w_stall = 1'b1;
        if (mem_gnt_i && (r_idx == w_lastIdx))
          w_nextState = isStore(r_op) ? MEM_DONE : MEM_WAIT;
      end
      MEM_WAIT: begin
        w_stall     = 1'b1;
        w_nextState = MEM_DONE;
      end
      MEM_DONE: w_nextState = MEM_IDLE;
      default:  w_nextState = MEM_IDLE;
    endcase
  end

  // The EX bundle is latched on entry so the access never depends on inputs once stall drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= MEM_IDLE;
      r_idx        <= 2'd0;
      r_op         <= EXE_NOP_OP;
      r_base       <= '0;
      r_rs2        <= '0;
      r_rdest      <= '0;
      r_we         <= 1'b0;
      r_trap       <= 1'b0;
      r_word       <= '0;
      r_capPending <= 1'b0;
      r_capIdx     <= 2'd0;
    end else begin
      r_state      <= w_nextState;
      r_capPending <= w_grant && isLoad(r_op);
      r_capIdx     <= r_idx;
      if (r_capPending)
        r_word[{r_capIdx, 3'b000} +: 8] <= mem_rdata_i;
      if ((r_state == MEM_IDLE) && w_inMem) begin
        r_op    <= ex_exec_i;
        r_base  <= ex_alu_i[ADDR_W-1:0];
        r_rs2   <= ex_rs2_i;
        r_rdest <= ex_rdest_i;
        r_we    <= ex_we_i;
        r_trap  <= w_trapIn;
        r_idx   <= 2'd0;
      end else if (w_grant) begin
        r_idx <= (r_idx == w_lastIdx) ? 2'd0 : r_idx + 2'd1;
      end
    end
  end

  mem_access_load_ext u_loadExt (
    .i_op   (r_op),
    .i_word (r_word),
    .o_data (w_ext)
  );

  // A bubble is written whenever upstream is held, so WB never sees a half-finished access.
  always_ff @(posedge clk) begin
    if (rst || w_stall) begin
      wb_data_o  <= '0;
      wb_rdest_o <= '0;
      wb_we_o    <= 1'b0;
    end else if (r_state == MEM_DONE) begin
      if (r_trap || isStore(r_op)) begin
        wb_data_o  <= '0;
        wb_rdest_o <= '0;
        wb_we_o    <= 1'b0;
      end else begin
        wb_data_o  <= w_ext;
        wb_rdest_o <= r_rdest;
        wb_we_o    <= r_we;
      end
    end else begin
      wb_data_o  <= ex_alu_i;
      wb_rdest_o <= ex_rdest_i;
      wb_we_o    <= ex_we_i;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_misalign;

  always_ff @(posedge clk) begin
    if (rst || w_stall)
      r_misalign <= 1'b0;
    else
      r_misalign <= (r_state == MEM_DONE) && r_trap;
  end

  assign mem_misalign_o = r_misalign;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access: a byte memory responder plus a
// spec-level model of each op's result, byte transfers and latency.
`timescale 1ns/1ps
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ex_exec_i = EXE_NOP_OP;
  logic [31:0] ex_alu_i = '0;
  logic [31:0] ex_rs2_i = '0;
  logic [4:0]  ex_rdest_i = '0;
  logic        ex_we_i = 1'b0;
  logic        mem_req_o, mem_wr_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic [7:0]  mem_rdata_i = '0;
  logic        stall_req_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rdest_o;
  logic        wb_we_o;
`ifdef MISALIGN_TRAP_EN
  logic        mem_misalign_o;
`endif

  mem_access dut (
    .clk         (clk),
    .rst         (rst),
    .ex_exec_i   (ex_exec_i),
    .ex_alu_i    (ex_alu_i),
    .ex_rs2_i    (ex_rs2_i),
    .ex_rdest_i  (ex_rdest_i),
    .ex_we_i     (ex_we_i),
    .mem_req_o   (mem_req_o),
    .mem_wr_o    (mem_wr_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rdata_i (mem_rdata_i),
    .stall_req_o (stall_req_o),
    .wb_data_o   (wb_data_o),
    .wb_rdest_o  (wb_rdest_o),
    .wb_we_o     (wb_we_o)
`ifdef MISALIGN_TRAP_EN
    ,
    .mem_misalign_o (mem_misalign_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Memory environment: envMem is written only by DUT transfers, refMem only by the model.
  logic [7:0]  envMem [bit [31:0]];
  logic [7:0]  refMem [bit [31:0]];
  logic [40:0] xferLog [$];
  int          gntMode = 0;
  logic        altPhase = 1'b0;
  logic        rdPending = 1'b0;
  logic [7:0]  rdNext = '0;
  logic        prevStuck = 1'b0;
  logic [39:0] prevAddrData = '0;

  function automatic logic [7:0] fillByte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : fillByte(a);
  endfunction

  function automatic logic [7:0] envRead(input logic [31:0] a);
    return envMem.exists(a) ? envMem[a] : fillByte(a);
  endfunction

  function automatic int opBytes(input logic [7:0] op);
    if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
    if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
    if (op == EXE_LW_OP || op == EXE_SW_OP) return 4;
    return 0;
  endfunction

  function automatic bit opIsStore(input logic [7:0] op);
    return op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
  endfunction

  always @(negedge clk) begin
    if (prevStuck && mem_req_o === 1'b1)
      checkOutput("addrHold", {24'h0, mem_addr_o, mem_wdata_o}, {24'h0, prevAddrData});
    prevStuck    = (mem_req_o === 1'b1) && !mem_gnt_i && !rst;
    prevAddrData = {mem_addr_o, mem_wdata_o};
    if (mem_req_o === 1'b1 && mem_gnt_i) begin
      xferLog.push_back({mem_wr_o, mem_addr_o, mem_wdata_o});
      if (mem_wr_o) envMem[mem_addr_o] = mem_wdata_o;
      else begin
        rdPending = 1'b1;
        rdNext    = envRead(mem_addr_o);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    mem_rdata_i = rdPending ? rdNext : 8'($urandom);
    rdPending   = 1'b0;
  end

  always @(posedge clk) begin
    #2;
    case (gntMode)
      0:       mem_gnt_i = 1'b1;
      1:       mem_gnt_i = 1'($urandom_range(0, 1));
      default: begin
        mem_gnt_i = altPhase;
        altPhase  = ~altPhase;
      end
    endcase
  end

  // Presents one op at the start of a cycle and checks WB, transfers and latency against the model.
  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] alu, input logic [31:0] rs2,
                               input logic [4:0] rdest, input logic we);
    int n, cyc, expLat;
    bit st, trap;
    logic [31:0] word, expData;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic [40:0] got, exp;
    n    = opBytes(op);
    st   = opIsStore(op);
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if ((n == 2 && alu[0]) || (n == 4 && alu[1:0] != 2'b00)) trap = 1'b1;
`endif
    xferLog.delete();
    ex_exec_i = op; ex_alu_i = alu; ex_rs2_i = rs2; ex_rdest_i = rdest; ex_we_i = we;
    cyc = 0;
    @(negedge clk);
    while (stall_req_o !== 1'b0 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    checkOutput("doneTimeout", 64'(cyc >= 200), 64'd0);
    if (n == 0) expLat = 0;
    else if (trap) expLat = 1;
    else expLat = st ? n + 1 : n + 2;
    if (gntMode == 0) checkOutput("latency", 64'(cyc), 64'(expLat));
    @(posedge clk);
    #1;
    word = '0;
    for (int k = 0; k < n; k++) word[8*k +: 8] = refRead(alu + 32'(k));
    sb = word[7:0];
    sh = word[15:0];
    if (n == 0) expData = alu;
    else if (st || trap) expData = '0;
    else if (op == EXE_LB_OP) expData = 32'(sb);
    else if (op == EXE_LH_OP) expData = 32'(sh);
    else expData = word;
    checkOutput("wbData", 64'(wb_data_o), 64'(expData));
    checkOutput("wbWe", 64'(wb_we_o), (n == 0 || !(st || trap)) ? 64'(we) : 64'd0);
    if (!(st || trap)) checkOutput("wbRdest", 64'(wb_rdest_o), 64'(rdest));
`ifdef MISALIGN_TRAP_EN
    checkOutput("misalign", 64'(mem_misalign_o), 64'(trap));
`endif
    checkOutput("xferCount", 64'(xferLog.size()), (n == 0 || trap) ? 64'd0 : 64'(n));
    if (!trap) begin
      for (int k = 0; k < n && k < xferLog.size(); k++) begin
        got = xferLog[k];
        if (!st) got[7:0] = 8'h00;
        exp = {st, alu + 32'(k), st ? rs2[8*k +: 8] : 8'h00};
        checkOutput("xfer", 64'(got), 64'(exp));
        if (st) refMem[alu + 32'(k)] = rs2[8*k +: 8];
      end
    end
    ex_exec_i = EXE_NOP_OP;
  endtask

  logic [7:0] opTable [12] = '{EXE_ADD_OP, EXE_SUB_OP, EXE_NOP_OP, EXE_LB_OP, EXE_LH_OP, EXE_LW_OP,
                               EXE_LBU_OP, EXE_LHU_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_OR_OP};

  initial begin
    logic [7:0]  op;
    logic [31:0] a;
    int grants;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstReq", 64'(mem_req_o), 64'd0);
    checkOutput("rstStall", 64'(stall_req_o), 64'd0);
    checkOutput("rstWb", {27'h0, wb_we_o, wb_rdest_o, wb_data_o}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    gntMode = 0;
    applyStimulus(EXE_ADD_OP, 32'h12345678, 32'h0, 5'd5, 1'b1);
    applyStimulus(EXE_SW_OP, 32'h100, 32'hA1B2C3D4, 5'd7, 1'b0);
    applyStimulus(EXE_SB_OP, 32'h180, 32'h55, 5'd0, 1'b0);
    envMem[32'h200] = 8'h80; refMem[32'h200] = 8'h80;
    applyStimulus(EXE_LB_OP, 32'h200, 32'h0, 5'd3, 1'b1);
    applyStimulus(EXE_LBU_OP, 32'h200, 32'h0, 5'd4, 1'b1);
    applyStimulus(EXE_LW_OP, 32'h100, 32'h0, 5'd9, 1'b1);

    envMem[32'h300] = 8'h34; refMem[32'h300] = 8'h34;
    envMem[32'h301] = 8'h92; refMem[32'h301] = 8'h92;
    altPhase = 1'b0;
    gntMode  = 2;
    applyStimulus(EXE_LH_OP, 32'h300, 32'h0, 5'd6, 1'b1);
    applyStimulus(EXE_SW_OP, 32'h310, 32'hDEADBEEF, 5'd0, 1'b0);

    gntMode = 0;
    ex_exec_i = EXE_LW_OP; ex_alu_i = 32'h400; ex_rdest_i = 5'd8; ex_we_i = 1'b1;
    grants = 0;
    for (int c = 0; c < 50 && grants < 2; c++) begin
      @(negedge clk);
      if (mem_req_o === 1'b1 && mem_gnt_i) grants++;
    end
    checkOutput("rstGrants", 64'(grants), 64'd2);
    @(posedge clk);
    #1 rst = 1'b1; ex_exec_i = EXE_NOP_OP;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstReq", 64'(mem_req_o), 64'd0);
    checkOutput("midRstStall", 64'(stall_req_o), 64'd0);
    checkOutput("midRstWb", {27'h0, wb_we_o, wb_rdest_o, wb_data_o}, 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(EXE_LB_OP, 32'h100, 32'h0, 5'd10, 1'b1);
    applyStimulus(EXE_LW_OP, 32'h102, 32'h0, 5'd11, 1'b1);

    for (int t = 0; t < 80; t++) begin
      gntMode = ($urandom_range(0, 3) == 0) ? 0 : 1;
      op = opTable[$urandom_range(0, 11)];
      if (opBytes(op) == 0) a = $urandom;
      else if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else a = 32'h1000 + 32'($urandom_range(0, 31));
      applyStimulus(op, a, $urandom, 5'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
